// File: rtl/usbframe_pkg.sv
// rtl/usbframe_pkg.sv - shared constants and types for the CH9350-style keyboard frame stream
package usbframe_pkg;

    localparam logic [23:0] MAGIC     = 24'h57AB01;
    localparam int          MAGIC_LEN = 3;
    localparam int          FRAME_LEN = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAGIC,
        ST_MASK,
        ST_RES,
        ST_CODE,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic [7:0] mask;
        logic [7:0] code;
    } key_event_t;

    // Byte idx of the magic header, most significant byte first on the wire.
    function automatic logic [7:0] magic_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = MAGIC[23:16];
            2'd1:    b = MAGIC[15:8];
            default: b = MAGIC[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/usbframe_fifo.sv
// rtl/usbframe_fifo.sv - synchronous FIFO with a combinational head output
module usbframe_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses a push even when it pops in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/usbframe_tx.sv
// rtl/usbframe_tx.sv - key event FIFO plus frame serializer producing 57 AB 01 mask 00 code
module usbframe_tx
    import usbframe_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int AUTO_RELEASE = 1,
    parameter int GAP          = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_key_valid,
    output logic       o_key_ready,
    input  logic [7:0] i_key_mask,
    input  logic [7:0] i_key_code,
    output logic       o_byte_valid,
    input  logic       i_byte_ready,
    output logic [7:0] o_byte
);

    localparam int EW = $bits(key_event_t);

    state_t     state;
    logic [1:0] idx;
    logic [7:0] mask_q;
    logic [7:0] code_q;
    logic       rel;
    logic [7:0] gap_cnt;
    logic       byte_valid;
    logic [7:0] byte_q;

    logic          fifo_full;
    logic          fifo_empty;
    logic [EW-1:0] head_bits;
    key_event_t    head_evt;
    key_event_t    in_evt;
    logic          pop;
    logic          accept;

    assign in_evt.mask = i_key_mask;
    assign in_evt.code = i_key_code;
    assign head_evt    = key_event_t'(head_bits);
    assign pop         = (state == ST_IDLE) && !fifo_empty;
    assign accept      = byte_valid && i_byte_ready;

    assign o_key_ready  = !fifo_full;
    assign o_byte_valid = byte_valid;
    assign o_byte       = byte_q;

    usbframe_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (i_key_valid),
        .wdata   (in_evt),
        .pop     (pop),
        .head    (head_bits),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            mask_q     <= '0;
            code_q     <= '0;
            rel        <= 1'b0;
            gap_cnt    <= '0;
            byte_valid <= 1'b0;
            byte_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        mask_q     <= head_evt.mask;
                        code_q     <= head_evt.code;
                        rel        <= 1'b0;
                        idx        <= '0;
                        byte_valid <= 1'b1;
                        byte_q     <= magic_byte(2'd0);
                        state      <= ST_MAGIC;
                    end
                end
                ST_MAGIC: begin
                    if (accept) begin
                        if (idx == 2'(MAGIC_LEN - 1)) begin
                            byte_q <= mask_q;
                            state  <= ST_MASK;
                        end else begin
                            idx    <= idx + 2'd1;
                            byte_q <= magic_byte(idx + 2'd1);
                        end
                    end
                end
                ST_MASK: begin
                    if (accept) begin
                        byte_q <= 8'h00;
                        state  <= ST_RES;
                    end
                end
                ST_RES: begin
                    if (accept) begin
                        byte_q <= code_q;
                        state  <= ST_CODE;
                    end
                end
                ST_CODE: begin
                    if (accept) begin
                        // The release frame follows its press directly; GAP only trails the pair.
                        if (AUTO_RELEASE != 0 && code_q != 8'h00 && !rel) begin
                            mask_q <= '0;
                            code_q <= '0;
                            rel    <= 1'b1;
                            idx    <= '0;
                            byte_q <= magic_byte(2'd0);
                            state  <= ST_MAGIC;
                        end else begin
                            rel        <= 1'b0;
                            byte_valid <= 1'b0;
                            byte_q     <= 8'h00;
                            gap_cnt    <= '0;
                            state      <= (GAP > 0) ? ST_GAP : ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 8'(GAP - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    byte_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usbframe_tx.sv
// tb/tb_usbframe_tx.sv - directed and randomized checks of usbframe_tx against a byte-queue model
module tb_usbframe_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       kv, kr, bv, rdy;
    logic [7:0] km, kc, bt;
    logic       kv_g, kr_g, bv_g, rdy_g;
    logic [7:0] km_g, kc_g, bt_g;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       held;
    logic [7:0] held_byte;

    always #5 clk = ~clk;

    usbframe_tx #(.FIFO_DEPTH(4), .AUTO_RELEASE(1), .GAP(0)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_key_valid  (kv),
        .o_key_ready  (kr),
        .i_key_mask   (km),
        .i_key_code   (kc),
        .o_byte_valid (bv),
        .i_byte_ready (rdy),
        .o_byte       (bt)
    );

    usbframe_tx #(.FIFO_DEPTH(4), .AUTO_RELEASE(1), .GAP(3)) dut_g (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_key_valid  (kv_g),
        .o_key_ready  (kr_g),
        .i_key_mask   (km_g),
        .i_key_code   (kc_g),
        .o_byte_valid (bv_g),
        .i_byte_ready (rdy_g),
        .o_byte       (bt_g)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected wire bytes for one accepted key event.
    task automatic model_event(input logic [7:0] m, input logic [7:0] c);
        exp_q.push_back(8'h57); exp_q.push_back(8'hAB); exp_q.push_back(8'h01);
        exp_q.push_back(m);     exp_q.push_back(8'h00); exp_q.push_back(c);
        if (c != 8'h00) begin
            exp_q.push_back(8'h57); exp_q.push_back(8'hAB); exp_q.push_back(8'h01);
            exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle on the main DUT: log handshakes before the edge, check hold after it.
    task automatic cyc_a();
        if (bv && rdy) got_q.push_back(bt);
        if (kv && kr) model_event(km, kc);
        held      = bv && !rdy;
        held_byte = bt;
        tick();
        if (held) begin
            check("hold_valid", bv, 1);
            check("hold_byte", bt, held_byte);
        end
    endtask

    task automatic drain_and_compare(input string tag, input int limit);
        int budget = 0;
        while (got_q.size() < exp_q.size() && budget < limit) begin
            cyc_a();
            budget++;
        end
        check({tag, "_budget"}, budget < limit, 1);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_byte"}, got_q[i], exp_q[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int sent;
        int budget;
        int acc;

        rst_n = 1'b0; kv = 0; km = 0; kc = 0; rdy = 0;
        kv_g = 0; km_g = 0; kc_g = 0; rdy_g = 0;
        held = 0; held_byte = 0;
        tick();
        tick();
        check("rst_valid", bv, 0);
        check("rst_byte", bt, 8'h00);
        check("rst_key_ready", kr, 1);
        check("rst_valid_g", bv_g, 0);
        check("rst_key_ready_g", kr_g, 1);
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", bv, 0);

        // Single press, ready high: 12 back-to-back bytes, first one two edges after acceptance.
        exp_q.delete();
        rdy = 1; kv = 1; km = 8'h02; kc = 8'h04;
        model_event(8'h02, 8'h04);
        check("t1_key_ready", kr, 1);
        tick();
        kv = 0;
        check("t1_latency", bv, 0);
        tick();
        for (int i = 0; i < 12; i++) begin
            check("t1_valid", bv, 1);
            check("t1_byte", bt, exp_q[i]);
            tick();
        end
        check("t1_idle_after", bv, 0);

        // Explicit release: one frame only.
        exp_q.delete();
        kv = 1; km = 8'h00; kc = 8'h00;
        model_event(8'h00, 8'h00);
        tick();
        kv = 0;
        tick();
        for (int i = 0; i < 6; i++) begin
            check("t2_valid", bv, 1);
            check("t2_byte", bt, exp_q[i]);
            tick();
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bv) seen++;
            tick();
        end
        check("t2_no_second_frame", seen, 0);

        // Random events with random consumer backpressure.
        exp_q.delete(); got_q.delete();
        sent = 0; budget = 0;
        while (budget < 4000 && (sent < 20 || got_q.size() < exp_q.size())) begin
            kv  = (sent < 20) && ($urandom_range(0, 2) != 0);
            km  = 8'($urandom);
            kc  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            rdy = 1'($urandom_range(0, 1));
            if (kv && kr) sent++;
            cyc_a();
            budget++;
        end
        kv = 0; rdy = 1;
        check("t3_budget", budget < 4000, 1);
        check("t3_events", sent, 20);
        check("t3_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("t3_byte", got_q[i], exp_q[i]);
        for (int i = 0; i < 4; i++) tick();
        check("t3_idle", bv, 0);

        // Six back-to-back offers while the consumer stalls.
        exp_q.delete(); got_q.delete();
        rdy = 0; acc = 0;
        for (int i = 0; i < 6; i++) begin
            kv = 1; km = 8'(8'h10 + i); kc = 8'(i + 1);
            if (kr) acc++;
            cyc_a();
        end
        kv = 0;
        check("t4_accepted", acc, 5);
        check("t4_ready_low", kr, 0);
        rdy = 1;
        drain_and_compare("t4", 500);
        for (int i = 0; i < 4; i++) tick();

        // GAP=3 instance: 3 gap cycles plus one idle cycle between the pairs.
        exp_q.delete();
        rdy_g = 1;
        kv_g = 1; km_g = 8'h01; kc_g = 8'h05;
        model_event(8'h01, 8'h05);
        check("t5_key_ready", kr_g, 1);
        tick();
        km_g = 8'h20; kc_g = 8'h06;
        model_event(8'h20, 8'h06);
        check("t5_key_ready2", kr_g, 1);
        tick();
        kv_g = 0;
        for (int c = 0; c < 28; c++) begin
            if (c < 12) begin
                check("t5_valid", bv_g, 1);
                check("t5_byte", bt_g, exp_q[c]);
            end else if (c < 16) begin
                check("t5_gap", bv_g, 0);
            end else begin
                check("t5_valid", bv_g, 1);
                check("t5_byte", bt_g, exp_q[c - 4]);
            end
            tick();
        end
        check("t5_end", bv_g, 0);

        // Reset mid-frame, just after 0xAB is taken, with another event still queued.
        rdy = 1; kv = 1; km = 8'h11; kc = 8'h22;
        tick();
        km = 8'h33; kc = 8'h44;
        tick();
        kv = 0;
        check("t6_b0", bt, 8'h57);
        tick();
        check("t6_b1", bt, 8'hAB);
        tick();
        check("t6_b2", bt, 8'h01);
        rst_n = 0;
        tick();
        check("t6_rst_valid", bv, 0);
        check("t6_rst_byte", bt, 8'h00);
        check("t6_rst_key_ready", kr, 1);
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bv) seen++;
            tick();
        end
        check("t6_stays_idle", seen, 0);
        exp_q.delete(); got_q.delete();
        kv = 1; km = 8'h02; kc = 8'h09;
        cyc_a();
        kv = 0;
        drain_and_compare("t6", 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
